// File: rtl/sample_change_logger.sv
// sample_change_logger: timestamps every change on din against a free-running counter
// and queues {value, ts} events in a show-ahead FIFO drained over valid/ready.
module sample_change_logger #(
    parameter int DATA_W = 4,
    parameter int TS_W   = 16,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          din,
    input  logic                       clr_ovf,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [TS_W-1:0]            out_ts,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TS_W-1:0]   ts;
    } entry_t;

    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic              primed_q, primed_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_q, drop_d, drop_base;
    logic              evt, full, pop, push, drop;

    always_comb begin
        evt        = !primed_q || (din != last_q);
        full       = count_q == CW'(DEPTH);
        pop        = (count_q != '0) && out_ready;
        // A full FIFO still accepts an event when the head leaves on the same edge
        push       = evt && (!full || pop);
        drop       = evt && full && !pop;
        ts_d       = ts_q + 1'b1;
        last_d     = din;
        primed_d   = 1'b1;
        mem_d      = mem_q;
        if (push)
            mem_d[wr_ptr_q] = {din, ts_q};
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + CW'(push) - CW'(pop);
        drop_base  = clr_ovf ? 8'd0 : drop_q;
        drop_d     = drop ? drop_base + 8'(drop_base != 8'hff) : drop_base;
        overflow_d = drop || (overflow_q && !clr_ovf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            ts_q       <= '0;
            last_q     <= '0;
            primed_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            mem_q      <= mem_d;
            ts_q       <= ts_d;
            last_q     <= last_d;
            primed_q   <= primed_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    assign out_valid = count_q != '0;
    assign out_data  = mem_q[rd_ptr_q].data;
    assign out_ts    = mem_q[rd_ptr_q].ts;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_sample_change_logger.sv
// tb_sample_change_logger: randomized and directed stimulus against a queue-based
// reference model; two DUTs (TS_W=16 and TS_W=4) share all inputs.
module tb_sample_change_logger;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] din = 4'hA;
    logic       clr_ovf = 1'b0;
    logic       out_ready = 1'b0;

    logic        valid_a, valid_b;
    logic [3:0]  data_a, data_b;
    logic [15:0] ts_a;
    logic [3:0]  ts_b;
    logic [3:0]  count_a, count_b;
    logic        ovf_a, ovf_b;
    logic [7:0]  drop_a, drop_b;

    sample_change_logger #(.DATA_W(4), .TS_W(16), .DEPTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(din), .clr_ovf(clr_ovf),
        .out_valid(valid_a), .out_ready(out_ready), .out_data(data_a), .out_ts(ts_a),
        .count(count_a), .overflow(ovf_a), .drop_cnt(drop_a));

    sample_change_logger #(.DATA_W(4), .TS_W(4), .DEPTH(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(din), .clr_ovf(clr_ovf),
        .out_valid(valid_b), .out_ready(out_ready), .out_data(data_b), .out_ts(ts_b),
        .count(count_b), .overflow(ovf_b), .drop_cnt(drop_b));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d;
        int         c;
    } ev_t;

    // Reference model: the FIFO is a plain queue of {value, cycle-since-reset}
    ev_t        exp_q[$];
    int         m_cyc, m_cnt, m_drops;
    logic [3:0] m_last;
    bit         m_primed, m_ovf, m_evt, m_pop, m_drop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_cyc = 0; m_cnt = 0; m_drops = 0; m_last = 4'h0;
            m_primed = 1'b0; m_ovf = 1'b0;
        end else begin
            m_evt  = !m_primed || din != m_last;
            m_pop  = out_ready && m_cnt > 0;
            m_drop = m_evt && m_cnt == 8 && !m_pop;
            if (m_evt && !m_drop) begin
                exp_q.push_back('{din, m_cyc});
                m_cnt++;
            end
            if (m_pop) m_cnt--;
            if (clr_ovf) begin
                m_ovf = 1'b0;
                m_drops = 0;
            end
            if (m_drop) begin
                m_ovf = 1'b1;
                m_drops = (m_drops < 255) ? m_drops + 1 : 255;
            end
            m_last = din;
            m_primed = 1'b1;
            m_cyc++;
        end
    end

    int n_tests = 0, n_fail = 0, rd_idx = 0;
    bit fin = 1'b0, fin_done = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            #1;
            chk("rst_valid", valid_a, 0);
            chk("rst_count", count_a, 0);
            chk("rst_ovf", ovf_a, 0);
            chk("rst_drop", drop_a, 0);
            chk("rst_data", data_a, 0);
            chk("rst_ts", ts_a, 0);
            chk("rst_valid_b", valid_b, 0);
            rd_idx = 0;
        end else begin
            chk("valid", valid_a, m_cnt != 0);
            chk("count", count_a, m_cnt);
            chk("overflow", ovf_a, m_ovf);
            chk("drop_cnt", drop_a, m_drops);
            chk("valid_b", valid_b, m_cnt != 0);
            chk("count_b", count_b, m_cnt);
            chk("drop_cnt_b", drop_b, m_drops);
            if (valid_a) begin
                if (rd_idx >= exp_q.size()) begin
                    chk("unexpected_entry", rd_idx, exp_q.size() - 1);
                end else begin
                    chk("data", data_a, exp_q[rd_idx].d);
                    chk("ts", ts_a, exp_q[rd_idx].c % 65536);
                    chk("data_b", data_b, exp_q[rd_idx].d);
                    chk("ts_b", ts_b, exp_q[rd_idx].c % 16);
                    if (out_ready) rd_idx++;
                end
            end
            if (fin && !fin_done) begin
                chk("drained", rd_idx, exp_q.size());
                fin_done = 1'b1;
            end
        end
    end

    task automatic step(input logic [3:0] d, input logic r, input logic c);
        @(posedge clk);
        #1;
        din = d; out_ready = r; clr_ovf = c;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [3:0] cur;

    initial begin
        // 1: constant input logs exactly one entry
        din = 4'hA; out_ready = 1'b1;
        do_reset();
        repeat (20) step(4'hA, 1, 0);
        // 2: sparse changes
        do_reset();
        repeat (50) step(4'hA, 1, 0);
        repeat (100) step(4'hC, 1, 0);
        repeat (20) step(4'h0, 1, 0);
        // 3: overflow with no consumer, then drain
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 11; i++) step((i % 2) ? 4'hA : 4'h5, 0, 0);
        repeat (3) step(4'h5, 0, 0);
        repeat (10) step(4'h5, 1, 0);
        // 4: full with simultaneous pop and event
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) step((i % 2) ? 4'h3 : 4'h6, 0, 0);
        step(4'hF, 1, 0);
        repeat (12) step(4'hF, 1, 0);
        // 5: clear coinciding with a drop, then held head
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 12; i++) step((i % 2) ? 4'h1 : 4'h2, 0, 0);
        step(4'h7, 0, 1);
        repeat (5) step(4'h7, 0, 0);
        step(4'h7, 0, 1);
        repeat (10) step(4'h7, 1, 0);
        // 6: narrow timestamp wrap, then reset with entries stored
        out_ready = 1'b0;
        do_reset();
        repeat (17) step(4'h9, 0, 0);
        step(4'h4, 0, 0);
        step(4'h8, 0, 0);
        repeat (3) step(4'h8, 0, 0);
        do_reset();
        // drop counter saturation
        for (int i = 0; i < 300; i++) step((i % 2) ? 4'hE : 4'hD, 0, 0);
        step(4'hD, 0, 1);
        repeat (10) step(4'hD, 1, 0);
        // randomized traffic
        cur = 4'h0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) cur = 4'($urandom_range(0, 15));
            step(cur, $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
            if (i % 1000 == 999) do_reset();
        end
        repeat (12) step(cur, 1, 0);
        fin = 1'b1;
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
